// File: rtl/mii_rx_frontend.sv
// rtl/mii_rx_frontend.sv - MII receive front-end: preamble/SFD strip, CRC32 and length check, FCS withholding
module mii_rx_frontend #(
  parameter int MIN_PRE = 7,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        r_clk,
  input  logic        rst,
  input  logic        r_dv,
  input  logic        r_er,
  input  logic [3:0]  datain,
  output logic [3:0]  dataout,
  output logic        out_dv,
  output logic        frame_done,
  output logic        frame_good,
  output logic        crc_err,
  output logic        len_err,
  output logic        phy_err,
  output logic [10:0] frame_len
);

  localparam logic [3:0]  MIN_PRE_N   = 4'(MIN_PRE);
  localparam logic [11:0] MIN_LEN_B   = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_B   = 12'(MAX_LEN);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state;
  logic        dv_q;
  logic        er_q;
  logic [3:0]  d_q;
  logic [3:0]  pre_cnt;
  logic [11:0] nib_cnt;
  logic [31:0] crc;
  logic [31:0] dline;    // 8-nibble delay line, newest in [3:0], oldest in [31:28]
  logic        phy_acc;  // sticky r_er for the frame in progress

  logic [31:0] crc_next;
  logic [11:0] byte_cnt;
  logic [10:0] len_calc;
  logic        crc_bad;
  logic        len_bad;

  // Reflected CRC32, one nibble per call, LSB of the nibble first
  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // End-of-frame status derived from the running counters
  always_comb begin
    crc_next = crc_nibble(crc, d_q);
    byte_cnt = {1'b0, nib_cnt[11:1]};
    len_calc = (nib_cnt[11:1] < 11'd4) ? 11'd0 : (nib_cnt[11:1] - 11'd4);
    crc_bad  = (crc != CRC_RESIDUE);
    len_bad  = nib_cnt[0] | (byte_cnt < MIN_LEN_B) | (byte_cnt > MAX_LEN_B);
  end

  // Register the raw MII inputs once before any use
  always_ff @(posedge r_clk) begin
    if (rst) begin
      dv_q <= 1'b0;
      er_q <= 1'b0;
      d_q  <= 4'h0;
    end else begin
      dv_q <= r_dv;
      er_q <= r_er;
      d_q  <= datain;
    end
  end

  // Receive FSM with registered stream and status outputs
  always_ff @(posedge r_clk) begin
    if (rst) begin
      state      <= IDLE;
      pre_cnt    <= 4'd0;
      nib_cnt    <= 12'd0;
      crc        <= 32'd0;
      dline      <= 32'd0;
      phy_acc    <= 1'b0;
      dataout    <= 4'h0;
      out_dv     <= 1'b0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      phy_err    <= 1'b0;
      frame_len  <= 11'd0;
    end else begin
      out_dv     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dv_q) begin
            if (d_q == 4'h5) begin
              state   <= PRE;
              pre_cnt <= 4'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PRE: begin
          if (!dv_q) begin
            state <= IDLE;
          end else if (d_q == 4'h5) begin
            if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
          end else if (d_q == 4'hD && pre_cnt >= MIN_PRE_N) begin
            state   <= DATA;
            crc     <= 32'hFFFFFFFF;
            nib_cnt <= 12'd0;
            dline   <= 32'd0;
            phy_acc <= 1'b0;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!dv_q) begin
            // Whatever is left in the delay line is the FCS and is dropped
            state      <= IDLE;
            frame_done <= 1'b1;
            crc_err    <= crc_bad;
            len_err    <= len_bad;
            phy_err    <= phy_acc;
            frame_good <= ~(crc_bad | len_bad | phy_acc);
            frame_len  <= len_calc;
          end else begin
            crc   <= crc_next;
            dline <= {dline[27:0], d_q};
            if (nib_cnt != 12'hFFF) nib_cnt <= nib_cnt + 12'd1;
            if (er_q) phy_acc <= 1'b1;
            if (nib_cnt >= 12'd8) begin
              out_dv  <= 1'b1;
              dataout <= dline[31:28];
            end
          end
        end
        DROP: begin
          if (!dv_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_frontend.sv
// tb/tb_mii_rx_frontend.sv - self-checking bench for mii_rx_frontend
module tb_mii_rx_frontend;

  logic        r_clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_dv = 1'b0;
  logic        r_er = 1'b0;
  logic [3:0]  datain = 4'h0;
  logic [3:0]  dataout;
  logic        out_dv;
  logic        frame_done;
  logic        frame_good;
  logic        crc_err;
  logic        len_err;
  logic        phy_err;
  logic [10:0] frame_len;

  always #5 r_clk = ~r_clk;

  mii_rx_frontend dut (
    .r_clk(r_clk), .rst(rst), .r_dv(r_dv), .r_er(r_er), .datain(datain),
    .dataout(dataout), .out_dv(out_dv), .frame_done(frame_done),
    .frame_good(frame_good), .crc_err(crc_err), .len_err(len_err),
    .phy_err(phy_err), .frame_len(frame_len)
  );

  typedef struct {
    int pre;
    int nbytes;
    bit flip;
    int er_at;
    bit good;
    bit crc;
    bit len;
    bit phy;
    int flen;
  } vec_t;

  typedef struct {
    bit good;
    bit crc;
    bit len;
    bit phy;
    int flen;
  } st_t;

  logic [3:0] q_nib[$];
  st_t        q_st[$];
  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int good_cnt = 0;
  logic [3:0] exp_n;
  st_t        es;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Scoreboard side: compare forwarded nibbles and end-of-frame status
  always @(negedge r_clk) begin
    if (out_dv) begin
      out_cnt++;
      if (q_nib.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_dv actual=%0h required=no_output", dataout);
      end else begin
        exp_n = q_nib.pop_front();
        check("dataout", 32'(dataout), 32'(exp_n));
      end
    end
    if (frame_done) begin
      done_cnt++;
      if (frame_good) good_cnt++;
      if (q_st.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done actual=1 required=0");
      end else begin
        es = q_st.pop_front();
        check("frame_good", 32'(frame_good), 32'(es.good));
        check("crc_err", 32'(crc_err), 32'(es.crc));
        check("len_err", 32'(len_err), 32'(es.len));
        check("phy_err", 32'(phy_err), 32'(es.phy));
        check("frame_len", 32'(frame_len), 32'(es.flen));
        check("pending_nibbles", 32'(q_nib.size()), 32'd0);
      end
    end
  end

  task automatic drive(input bit dv, input bit er, input logic [3:0] d);
    @(posedge r_clk);
    #1;
    r_dv = dv;
    r_er = er;
    datain = d;
  endtask

  task automatic outputs_zero(input string name);
    check(name, 32'({dataout, out_dv, frame_done, frame_good, crc_err, len_err, phy_err, frame_len}), 32'd0);
  endtask

  // Build a frame with valid FCS, optionally corrupt it, and drive it; rx=0 means no output expected
  task automatic send_frame(input int pre, input int nbytes, input bit flip, input int er_at,
                            input int abort_at, input bit rx, input st_t exp);
    logic [7:0]  fb[2048];
    logic [31:0] c;
    logic [3:0]  nib;
    int total;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nbytes - 4; i++) begin
      fb[i] = 8'((i * 7 + 3) & 255);
      c = crc_byte(c, fb[i]);
    end
    c = ~c;
    fb[nbytes-4] = c[7:0];
    fb[nbytes-3] = c[15:8];
    fb[nbytes-2] = c[23:16];
    fb[nbytes-1] = c[31:24];
    if (flip) fb[20] = fb[20] ^ 8'h08;
    if (rx && abort_at < 0) q_st.push_back(exp);
    for (int i = 0; i < pre; i++) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    total = nbytes * 2;
    for (int k = 0; k < total; k++) begin
      nib = k[0] ? fb[k/2][7:4] : fb[k/2][3:0];
      if (k == abort_at) begin
        @(posedge r_clk);
        #1;
        rst = 1'b1;
        r_dv = 1'b1;
        r_er = 1'b0;
        datain = 4'hA;
        @(posedge r_clk);
        #1;
        outputs_zero("rst_mid_frame_outputs");
        q_nib.delete();
        rst = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 4'hA);
        drive(1'b0, 1'b0, 4'h0);
        return;
      end
      if (rx && k < total - 8) q_nib.push_back(nib);
      drive(1'b1, (k == er_at), nib);
    end
    drive(1'b0, 1'b0, 4'h0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (q_st.size() != 0 && n < 40) begin
      @(posedge r_clk);
      n++;
    end
    check(name, 32'(q_st.size()), 32'd0);
    repeat (3) @(posedge r_clk);
  endtask

  vec_t tbl[8];
  st_t  st;
  st_t  none;
  int   d0;
  int   o0;
  int   g0;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{pre: 15, nbytes: 64,   flip: 0, er_at: -1, good: 1, crc: 0, len: 0, phy: 0, flen: 60};
    tbl[1] = '{pre: 15, nbytes: 64,   flip: 1, er_at: -1, good: 0, crc: 1, len: 0, phy: 0, flen: 60};
    tbl[2] = '{pre: 15, nbytes: 64,   flip: 0, er_at: 60, good: 0, crc: 0, len: 0, phy: 1, flen: 60};
    tbl[3] = '{pre: 15, nbytes: 40,   flip: 0, er_at: -1, good: 0, crc: 0, len: 1, phy: 0, flen: 36};
    tbl[4] = '{pre: 7,  nbytes: 63,   flip: 0, er_at: -1, good: 0, crc: 0, len: 1, phy: 0, flen: 59};
    tbl[5] = '{pre: 20, nbytes: 100,  flip: 0, er_at: -1, good: 1, crc: 0, len: 0, phy: 0, flen: 96};
    tbl[6] = '{pre: 8,  nbytes: 1518, flip: 0, er_at: -1, good: 1, crc: 0, len: 0, phy: 0, flen: 1514};
    tbl[7] = '{pre: 8,  nbytes: 1519, flip: 0, er_at: -1, good: 0, crc: 0, len: 1, phy: 0, flen: 1515};
    none = '{good: 0, crc: 0, len: 0, phy: 0, flen: 0};

    repeat (3) @(posedge r_clk);
    #1;
    outputs_zero("reset_outputs");
    rst = 1'b0;
    repeat (2) @(posedge r_clk);

    for (int i = 0; i < 8; i++) begin
      st = '{good: tbl[i].good, crc: tbl[i].crc, len: tbl[i].len, phy: tbl[i].phy, flen: tbl[i].flen};
      o0 = out_cnt;
      send_frame(tbl[i].pre, tbl[i].nbytes, tbl[i].flip, tbl[i].er_at, -1, 1'b1, st);
      wait_idle($sformatf("done_vec%0d", i));
      check($sformatf("fwd_count_vec%0d", i), 32'(out_cnt - o0), 32'((tbl[i].nbytes - 4) * 2));
    end

    // Bad preamble 5,5,3 drops the frame; a following good frame is received
    d0 = done_cnt;
    o0 = out_cnt;
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'h3);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, (i == 4) ? 4'hD : 4'h5);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 4'(i));
    drive(1'b0, 1'b0, 4'h0);
    repeat (15) @(posedge r_clk);
    check("drop_bad_pre_done", 32'(done_cnt - d0), 32'd0);
    check("drop_bad_pre_dv", 32'(out_cnt - o0), 32'd0);
    send_frame(15, 64, 1'b0, -1, -1, 1'b1, '{good: 1, crc: 0, len: 0, phy: 0, flen: 60});
    wait_idle("done_after_drop");

    // One preamble nibble short of the minimum
    d0 = done_cnt;
    o0 = out_cnt;
    send_frame(6, 64, 1'b0, -1, -1, 1'b0, none);
    repeat (20) @(posedge r_clk);
    check("short_pre_done", 32'(done_cnt - d0), 32'd0);
    check("short_pre_dv", 32'(out_cnt - o0), 32'd0);

    // Only 3 nibbles after the SFD
    o0 = out_cnt;
    q_st.push_back('{good: 0, crc: 1, len: 1, phy: 0, flen: 0});
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'h5);
    drive(1'b1, 1'b0, 4'hD);
    drive(1'b1, 1'b0, 4'h1);
    drive(1'b1, 1'b0, 4'h2);
    drive(1'b1, 1'b0, 4'h3);
    drive(1'b0, 1'b0, 4'h0);
    wait_idle("done_tiny");
    check("tiny_dv", 32'(out_cnt - o0), 32'd0);

    // Reset at payload nibble 50, then stray non-preamble data goes to DROP
    send_frame(15, 64, 1'b0, -1, -1, 1'b1, '{good: 1, crc: 0, len: 0, phy: 0, flen: 60});
    wait_idle("done_before_rst");
    d0 = done_cnt;
    send_frame(15, 64, 1'b0, -1, 50, 1'b1, none);
    o0 = out_cnt;
    repeat (20) @(posedge r_clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_no_dv", 32'(out_cnt - o0), 32'd0);

    // Two good frames separated by a single idle cycle
    d0 = done_cnt;
    g0 = good_cnt;
    send_frame(7, 64, 1'b0, -1, -1, 1'b1, '{good: 1, crc: 0, len: 0, phy: 0, flen: 60});
    send_frame(7, 70, 1'b0, -1, -1, 1'b1, '{good: 1, crc: 0, len: 0, phy: 0, flen: 66});
    wait_idle("done_b2b");
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_good_count", 32'(good_cnt - g0), 32'd2);
    check("final_nib_queue", 32'(q_nib.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
